// File: rtl/overlap_add_pkg.sv
// Shared constants and state encoding for the STFT synthesis path
// (overlap_add and hann_window).
package overlap_add_pkg;

    localparam int I_BW_DEF       = 14;
    localparam int O_BW_DEF       = 15;
    localparam int FRAME_LEN_DEF  = 1024;
    localparam int HOP_DEF        = 512;
    localparam int TOTAL_DATA_DEF = 91136;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } oa_state_e;

endpackage

// File: rtl/overlap_tail_ram.sv
// Simple dual-port tail buffer: one write port, one registered read port.
module overlap_tail_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 14,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [AW-1:0]           waddr_i,
    input  logic signed [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]           raddr_i,
    output logic signed [WIDTH-1:0] rdata_o
);

    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic signed [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/overlap_add.sv
// Overlap-add reconstruction: first half of each frame is summed with the
// stored second half of the previous frame; a flush drains the final tail.
module overlap_add
    import overlap_add_pkg::*;
#(
    parameter int I_BW       = I_BW_DEF,
    parameter int O_BW       = O_BW_DEF,
    parameter int FRAME_LEN  = FRAME_LEN_DEF,
    parameter int HOP        = HOP_DEF,
    parameter int TOTAL_DATA = TOTAL_DATA_DEF,
    localparam int IDX_W     = $clog2(FRAME_LEN),
    localparam int HOP_W     = $clog2(HOP),
    localparam int NUM_W     = $clog2(TOTAL_DATA / FRAME_LEN) + 1,
    localparam int ONUM_W    = $clog2(TOTAL_DATA)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [I_BW-1:0] data_i,
    input  logic                   di_en,
    input  logic [IDX_W-1:0]       in_group_idx,
    input  logic [NUM_W-1:0]       in_group_num,
    input  logic                   flush,
    output logic signed [O_BW-1:0] data_o,
    output logic                   do_en,
    output logic [ONUM_W-1:0]      out_num,
    output logic                   flush_busy,
    output logic                   seq_err
);

    oa_state_e state_q, state_d;

    logic [IDX_W-1:0]       exp_idx_q, exp_idx_d;
    logic [NUM_W-1:0]       exp_num_q, exp_num_d;
    logic [HOP_W-1:0]       fcnt_q, fcnt_d;
    logic [ONUM_W-1:0]      out_num_q;
    logic                   seq_err_q;

    logic                   v1_q, m1_q, v2_q;
    logic signed [I_BW-1:0] x1_q;
    logic signed [O_BW-1:0] sum_q;

    logic                   flush_start, flush_bad, flush_done;
    logic                   accept, in_hi, frame_end;
    logic                   ram_we;
    logic [HOP_W-1:0]       ram_raddr;
    logic signed [I_BW-1:0] ram_rdata;
    logic signed [O_BW-1:0] tail_ext, flush_word;

    // A flush arriving together with a sample wins; the sample is dropped as an error.
    assign flush_start = flush && (state_q == IDLE);
    assign flush_bad   = flush && (state_q != IDLE);
    assign flush_done  = (state_q == FLUSH) && (fcnt_q == HOP_W'(HOP - 1));
    assign accept      = di_en && (in_group_idx == exp_idx_q) && (in_group_num == exp_num_q)
                         && (state_q != FLUSH) && !flush_start;
    assign in_hi       = (in_group_idx >= IDX_W'(HOP));
    assign frame_end   = accept && (in_group_idx == IDX_W'(FRAME_LEN - 1));
    assign ram_we      = accept && in_hi;

    // During FLUSH the read runs one word ahead so each tail word is ready the cycle it is emitted.
    always_comb begin
        if (state_q == FLUSH) begin
            ram_raddr = fcnt_q + HOP_W'(1);
        end else if (flush_start) begin
            ram_raddr = '0;
        end else begin
            ram_raddr = in_group_idx[HOP_W-1:0];
        end
    end

    overlap_tail_ram #(
        .DEPTH (HOP),
        .WIDTH (I_BW)
    ) u_tail (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (in_group_idx[HOP_W-1:0]),
        .wdata_i (data_i),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush_start) begin
                    state_d = FLUSH;
                end else if (accept) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (frame_end) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (flush_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tail_ext = O_BW'(ram_rdata);

    always_comb begin
        flush_busy = (state_q == FLUSH);
        flush_word = (exp_num_q == '0) ? '0 : tail_ext;
        do_en      = v2_q || flush_busy;
        data_o     = flush_busy ? flush_word : sum_q;
    end

    always_comb begin
        exp_idx_d = exp_idx_q;
        exp_num_d = exp_num_q;
        fcnt_d    = fcnt_q;
        if (accept) begin
            if (frame_end) begin
                exp_idx_d = '0;
                exp_num_d = exp_num_q + NUM_W'(1);
            end else begin
                exp_idx_d = exp_idx_q + IDX_W'(1);
            end
        end
        if (flush_start) begin
            fcnt_d = '0;
        end else if (state_q == FLUSH) begin
            fcnt_d = fcnt_q + HOP_W'(1);
        end
        if (flush_done) begin
            exp_idx_d = '0;
            exp_num_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_idx_q <= '0;
            exp_num_q <= '0;
            fcnt_q    <= '0;
            out_num_q <= '0;
            seq_err_q <= 1'b0;
        end else begin
            exp_idx_q <= exp_idx_d;
            exp_num_q <= exp_num_d;
            fcnt_q    <= fcnt_d;
            out_num_q <= out_num_q + ONUM_W'(do_en);
            seq_err_q <= seq_err_q || (di_en && !accept) || flush_bad;
        end
    end

    // Two-stage sum pipeline; m1_q masks the tail while no previous frame exists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            m1_q  <= 1'b0;
            x1_q  <= '0;
            v2_q  <= 1'b0;
            sum_q <= '0;
        end else begin
            v1_q <= accept && !in_hi;
            if (accept) begin
                x1_q <= data_i;
                m1_q <= (exp_num_q == '0);
            end
            v2_q <= v1_q;
            if (v1_q) begin
                sum_q <= O_BW'(x1_q) + (m1_q ? O_BW'(0) : tail_ext);
            end
        end
    end

    assign out_num = out_num_q;
    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_overlap_add.sv
// Directed bench for overlap_add: streaming sums, flush drain, ordering
// errors and mid-frame reset, with hand-computed expected samples.
module tb_overlap_add;

    localparam int I_BW   = 14;
    localparam int O_BW   = 15;
    localparam int IDX_W  = 10;
    localparam int NUM_W  = 8;
    localparam int ONUM_W = 17;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic signed [I_BW-1:0] data_i = '0;
    logic                   di_en = 1'b0;
    logic [IDX_W-1:0]       in_group_idx = '0;
    logic [NUM_W-1:0]       in_group_num = '0;
    logic                   flush = 1'b0;
    logic signed [O_BW-1:0] data_o;
    logic                   do_en;
    logic [ONUM_W-1:0]      out_num;
    logic                   flush_busy;
    logic                   seq_err;

    int vectors     = 0;
    int miscompares = 0;
    int expOutNum   = 0;
    logic prevV     = 1'b0;
    int prevD       = 0;

    overlap_add dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .di_en        (di_en),
        .in_group_idx (in_group_idx),
        .in_group_num (in_group_num),
        .flush        (flush),
        .data_o       (data_o),
        .do_en        (do_en),
        .out_num      (out_num),
        .flush_busy   (flush_busy),
        .seq_err      (seq_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drives one cycle of input from a negedge; checks the output due from the previous step.
    task automatic applyStimulus(input logic en, input int idx, input int num, input int val,
                                 input logic fl, input logic expV, input int expD);
        di_en        = en;
        in_group_idx = IDX_W'(idx);
        in_group_num = NUM_W'(num);
        data_i       = I_BW'(val);
        flush        = fl;
        @(posedge clk);
        @(negedge clk);
        checkOutput("do_en", do_en, prevV);
        if (prevV) begin
            checkOutput("data_o", data_o, prevD);
            checkOutput("out_num", out_num, expOutNum);
            expOutNum++;
        end
        prevV = expV;
        prevD = expD;
        di_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic applyReset();
        di_en = 1'b0;
        flush = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_do_en", do_en, 0);
        checkOutput("rst_data_o", data_o, 0);
        checkOutput("rst_out_num", out_num, 0);
        checkOutput("rst_flush_busy", flush_busy, 0);
        checkOutput("rst_seq_err", seq_err, 0);
        rst       = 1'b0;
        prevV     = 1'b0;
        expOutNum = 0;
    endtask

    task automatic doFlush(input int val);
        flush = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            flush = 1'b0;
            checkOutput("flush_busy_hi", flush_busy, 1);
            checkOutput("flush_do_en", do_en, 1);
            checkOutput("flush_data", data_o, val);
            checkOutput("flush_out_num", out_num, expOutNum);
            expOutNum++;
        end
        @(negedge clk);
        checkOutput("flush_busy_lo", flush_busy, 0);
        checkOutput("flush_do_en_lo", do_en, 0);
        prevV = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        applyReset();

        // Frame 0 of 100 then frame 1 of 50, back to back, then drain the tail of 50.
        for (int i = 0; i < 1024; i++) applyStimulus(1, i, 0, 100, 0, i < 512, 100);
        for (int i = 0; i < 1024; i++) applyStimulus(1, i, 1, 50, 0, i < 512, 150);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_seq_err", seq_err, 0);
        checkOutput("t1_out_num_end", out_num, 1024);
        doFlush(50);
        checkOutput("t1_out_num_after_flush", out_num, 1536);

        // Full-scale negative frames sum without overflow.
        applyReset();
        for (int i = 0; i < 1024; i++) applyStimulus(1, i, 0, -8192, 0, i < 512, -8192);
        for (int i = 0; i < 1024; i++) applyStimulus(1, i, 1, -8192, 0, i < 512, -16384);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Duplicate idx 5 in frame 0 is dropped; frame 1 of zeros exposes the stored tail.
        applyReset();
        for (int i = 0; i < 6; i++) applyStimulus(1, i, 0, i, 0, 1, i);
        applyStimulus(1, 5, 0, 999, 0, 0, 0);
        checkOutput("t3_seq_err", seq_err, 1);
        for (int i = 6; i < 1024; i++) applyStimulus(1, i, 0, i, 0, i < 512, i);
        for (int i = 0; i < 1024; i++) applyStimulus(1, i, 1, 0, 0, i < 512, i + 512);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Flush during streaming is an error and leaves the stream intact.
        applyReset();
        for (int i = 0; i < 1024; i++) applyStimulus(1, i, 0, 20, 0, i < 512, 20);
        checkOutput("t4_seq_err_before", seq_err, 0);
        for (int i = 0; i < 1024; i++) applyStimulus(1, i, 1, 30, i == 300, i < 512, 50);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_seq_err_after", seq_err, 1);
        checkOutput("t4_flush_busy", flush_busy, 0);

        // Reset at idx 700 of frame 2, then a fresh stream must ignore the stale tail.
        applyReset();
        for (int i = 0; i < 1024; i++) applyStimulus(1, i, 0, 3, 0, i < 512, 3);
        for (int i = 0; i < 1024; i++) applyStimulus(1, i, 1, 3, 0, i < 512, 6);
        for (int i = 0; i < 700; i++) applyStimulus(1, i, 2, 3, 0, i < 512, 6);
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1024; i++) applyStimulus(1, i, 0, 7, 0, i < 512, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_seq_err", seq_err, 0);
        checkOutput("t5_out_num_end", out_num, 512);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
